// File: rtl/arbiter_1_to_n_response_control_if.sv
// Bundle of the response-side control network signals between one producer
// and NUM_CONTROL_RECEIVER consumers.
//
// Handshake: the producer may present response_in_valid with a payload only
// while the previous cycle showed response_ready_out=1 and
// fifo_setup_signal=0. There is no per-transfer acknowledge; a packet is
// taken every cycle valid is high, and ready is advisory backpressure with
// a 4-entry margin per FIFO. Each consumer pops by raising rd_en[i]. A popped
// entry appears as a single-cycle response_out_valid[i] pulse with its
// payload. A rd_en on an empty FIFO produces no pulse.
//
//   response_in_valid/payload   producer -> block   incoming ControlPacket
//   rd_en[N]                    consumer -> block   per-port pop request
//   fifo_empty/prog_full[N]     block -> consumer   registered FIFO state
//   response_out_valid/payload  block -> consumer   per-port delivered packet
//   response_ready_out          block -> producer   room for more packets
//   drop_count                  block -> monitor    misrouted packet count
//   fifo_setup_signal           block -> producer   FIFOs still in reset
interface arbiter_1_to_n_response_control_if #(
  parameter int NUM_CONTROL_RECEIVER = 2,
  parameter int PAYLOAD_WIDTH        = 32
);
  logic                                                response_in_valid;
  logic [PAYLOAD_WIDTH-1:0]                            response_in_payload;
  logic [NUM_CONTROL_RECEIVER-1:0]                     rd_en;
  logic [NUM_CONTROL_RECEIVER-1:0]                     fifo_empty;
  logic [NUM_CONTROL_RECEIVER-1:0]                     fifo_prog_full;
  logic [NUM_CONTROL_RECEIVER-1:0]                     response_out_valid;
  logic [NUM_CONTROL_RECEIVER-1:0][PAYLOAD_WIDTH-1:0]  response_out_payload;
  logic                                                response_ready_out;
  logic [15:0]                                         drop_count;
  logic                                                fifo_setup_signal;

  modport master (
    output response_in_valid, response_in_payload, rd_en,
    input  fifo_empty, fifo_prog_full, response_out_valid, response_out_payload,
    input  response_ready_out, drop_count, fifo_setup_signal
  );

  modport slave (
    input  response_in_valid, response_in_payload, rd_en,
    output fifo_empty, fifo_prog_full, response_out_valid, response_out_payload,
    output response_ready_out, drop_count, fifo_setup_signal
  );
endinterface

// File: rtl/arbiter_1_to_n_response_control.sv
// 1-to-N response distributor. A single ControlPacket stream is steered by
// the destination index found at payload[DEST_LSB +: DEST_WIDTH] into one of
// NUM_CONTROL_RECEIVER per-destination FIFOs, and each consumer pops its own
// FIFO independently. Out-of-range destinations are dropped and counted.
//
// Ports:
//   ap_clk   clock
//   areset   synchronous active-high reset; registered once before use
//   resp_if  slave side of arbiter_1_to_n_response_control_if
//
// Pipeline: input register -> routed write register -> FIFO push.
// Pop path: rd_en register -> FIFO read register -> response_out register.
module arbiter_1_to_n_response_control #(
  parameter int NUM_CONTROL_RECEIVER = 2,
  parameter int PAYLOAD_WIDTH        = 32,
  parameter int DEST_WIDTH           = (NUM_CONTROL_RECEIVER > 1) ? $clog2(NUM_CONTROL_RECEIVER) : 1,
  parameter int DEST_LSB             = 0,
  parameter int FIFO_WRITE_DEPTH     = 16,
  parameter int PROG_THRESH          = 12,
  parameter int RST_BUSY_CYCLES      = 4
) (
  input logic ap_clk,
  input logic areset,
  arbiter_1_to_n_response_control_if.slave resp_if
);
  localparam int N  = NUM_CONTROL_RECEIVER;
  localparam int PW = PAYLOAD_WIDTH;
  localparam int AW = (FIFO_WRITE_DEPTH > 1) ? $clog2(FIFO_WRITE_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = $clog2(RST_BUSY_CYCLES + 1);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_WRITE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reset fan-out: three registered copies keep the reset net local to each
  // region; every region therefore sees reset one cycle after areset.
  logic ctrl_rst_q, fifo_rst_q, router_rst_q;
  always_ff @(posedge ap_clk) begin
    ctrl_rst_q   <= areset;
    fifo_rst_q   <= areset;
    router_rst_q <= areset;
  end

  // Stage 1: input capture
  logic          in_valid_q;
  logic [PW-1:0] in_payload_q;
  logic [N-1:0]  rd_en_q;
  always_ff @(posedge ap_clk) begin
    if (router_rst_q) begin
      in_valid_q <= 1'b0;
      rd_en_q    <= '0;
    end else begin
      in_valid_q <= resp_if.response_in_valid;
      rd_en_q    <= resp_if.rd_en;
    end
  end

  // Stage 2: destination decode into a one-hot write enable
  logic [DEST_WIDTH-1:0] dest;
  logic                  dest_ok;
  logic [N-1:0]          wr_sel_d, wr_en_q;
  logic [PW-1:0]         wr_data_q;
  logic [15:0]           drop_count_q;

  assign dest    = in_payload_q[DEST_LSB +: DEST_WIDTH];
  // Widened by one bit so N == 2**DEST_WIDTH compares correctly.
  assign dest_ok = ({1'b0, dest} < (DEST_WIDTH + 1)'(N));

  always_comb begin
    wr_sel_d = '0;
    for (int i = 0; i < N; i++) begin
      wr_sel_d[i] = in_valid_q && dest_ok && (dest == DEST_WIDTH'(i));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (router_rst_q) begin
      wr_en_q      <= '0;
      drop_count_q <= '0;
    end else begin
      wr_en_q <= wr_sel_d;
      if (in_valid_q && !dest_ok && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  // Per-destination FIFOs
  logic [PW-1:0] mem_q      [N][FIFO_WRITE_DEPTH];
  logic [AW-1:0] wr_ptr_q   [N];
  logic [AW-1:0] rd_ptr_q   [N];
  logic [CW-1:0] count_q    [N];
  logic [BW-1:0] busy_cnt_q [N];
  logic [PW-1:0] rd_data_q  [N];
  logic [N-1:0]  rd_valid_q;
  logic [N-1:0]  empty, full, prog_full, busy, push, pop;

  // A push into a full FIFO is discarded, and nothing moves while a FIFO is
  // still coming out of reset.
  always_comb begin
    empty     = '0;
    full      = '0;
    prog_full = '0;
    busy      = '0;
    push      = '0;
    pop       = '0;
    for (int i = 0; i < N; i++) begin
      empty[i]     = (count_q[i] == '0);
      full[i]      = (count_q[i] == CW'(FIFO_WRITE_DEPTH));
      prog_full[i] = (count_q[i] >= CW'(PROG_THRESH));
      busy[i]      = fifo_rst_q | (busy_cnt_q[i] != '0);
      push[i]      = wr_en_q[i] & ~full[i] & ~busy[i];
      pop[i]       = rd_en_q[i] & ~empty[i] & ~busy[i];
    end
  end

  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < N; i++) begin
      if (fifo_rst_q) begin
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
        count_q[i]    <= '0;
        busy_cnt_q[i] <= BW'(RST_BUSY_CYCLES);
        rd_valid_q[i] <= 1'b0;
      end else begin
        if (busy_cnt_q[i] != '0) busy_cnt_q[i] <= busy_cnt_q[i] - 1'b1;
        if (push[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
        if (pop[i])  rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
        unique case ({push[i], pop[i]})
          2'b10:   count_q[i] <= count_q[i] + 1'b1;
          2'b01:   count_q[i] <= count_q[i] - 1'b1;
          default: count_q[i] <= count_q[i];
        endcase
        rd_valid_q[i] <= pop[i];
      end
    end
  end

  // Payload storage and datapath registers carry no reset.
  logic [N-1:0][PW-1:0] out_payload_q;
  always_ff @(posedge ap_clk) begin
    in_payload_q <= resp_if.response_in_payload;
    wr_data_q    <= in_payload_q;
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= wr_data_q;
      if (pop[i])  rd_data_q[i] <= mem_q[i][rd_ptr_q[i]];
      out_payload_q[i] <= rd_data_q[i];
    end
  end

  // Output and status registers
  logic [N-1:0] out_valid_q, out_empty_q, out_prog_full_q;
  logic         setup_q, ready_q;
  always_ff @(posedge ap_clk) begin
    if (ctrl_rst_q) begin
      out_valid_q     <= '0;
      out_empty_q     <= '1;
      out_prog_full_q <= '0;
      setup_q         <= 1'b1;
      ready_q         <= 1'b0;
    end else begin
      out_valid_q     <= rd_valid_q;
      out_empty_q     <= empty;
      out_prog_full_q <= prog_full;
      setup_q         <= |busy;
      // Ready uses the registered setup flag, so it rises one cycle after
      // fifo_setup_signal falls.
      ready_q         <= ~(|prog_full) & ~setup_q;
    end
  end

  assign resp_if.response_out_valid   = out_valid_q;
  assign resp_if.response_out_payload = out_payload_q;
  assign resp_if.fifo_empty           = out_empty_q;
  assign resp_if.fifo_prog_full       = out_prog_full_q;
  assign resp_if.response_ready_out   = ready_q;
  assign resp_if.drop_count           = drop_count_q;
  assign resp_if.fifo_setup_signal    = setup_q;
endmodule

// File: tb/tb_arbiter_1_to_n_response_control.sv
module tb_arbiter_1_to_n_response_control;
  localparam int N  = 3;
  localparam int PW = 16;

  logic ap_clk;
  logic areset;

  arbiter_1_to_n_response_control_if #(.NUM_CONTROL_RECEIVER(N), .PAYLOAD_WIDTH(PW)) vif ();

  arbiter_1_to_n_response_control #(
    .NUM_CONTROL_RECEIVER(N),
    .PAYLOAD_WIDTH(PW),
    .DEST_LSB(8)
  ) dut (
    .ap_clk (ap_clk),
    .areset (areset),
    .resp_if(vif)
  );

  // clock / reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  logic [PW-1:0] got_q [N][$];
  logic [PW-1:0] exp_q [N][$];

  always @(negedge ap_clk) begin
    for (int p = 0; p < N; p++) begin
      if (vif.response_out_valid[p] === 1'b1) got_q[p].push_back(vif.response_out_payload[p]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // payload layout: [15:10] filler, [9:8] destination, [7:0] data
  function automatic logic [PW-1:0] mk(input int dest, input logic [7:0] data);
    logic [5:0] hi;
    hi = 6'($urandom_range(0, 63));
    return {hi, 2'(dest), data};
  endfunction

  // drivers
  task automatic send(input logic [PW-1:0] p);
    @(negedge ap_clk);
    vif.response_in_valid   = 1'b1;
    vif.response_in_payload = p;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge ap_clk);
      vif.response_in_valid = 1'b0;
    end
  endtask

  task automatic pop(input logic [N-1:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge ap_clk);
      vif.response_in_valid = 1'b0;
      vif.rd_en = mask;
    end
    @(negedge ap_clk);
    vif.rd_en = '0;
  endtask

  task automatic clear_got();
    for (int p = 0; p < N; p++) got_q[p].delete();
  endtask

  task automatic wait_ready(input string tag);
    int   n    = 0;
    bit   seen = 0;
    logic rdy_at_fall = 1'b1;
    while (n < 60) begin
      if (!seen && vif.fifo_setup_signal === 1'b0) begin
        seen = 1;
        rdy_at_fall = vif.response_ready_out;
      end
      if (vif.fifo_setup_signal === 1'b0 && vif.response_ready_out === 1'b1) break;
      @(negedge ap_clk);
      n++;
    end
    check({tag, " setup_low"}, 32'(vif.fifo_setup_signal), 0);
    check({tag, " ready_high"}, 32'(vif.response_ready_out), 1);
    check({tag, " ready_after_setup"}, 32'(rdy_at_fall), 0);
  endtask

  typedef struct {
    int         dest;
    logic [7:0] data;
    int         exp_port;   // -1: dropped
  } vec_t;
  vec_t vecs [10];

  initial begin
    logic [PW-1:0] p;
    logic [PW-1:0] burst [$];
    int   d, n;

    vecs[0] = '{2, 8'hA5, 2};
    vecs[1] = '{0, 8'h11, 0};
    vecs[2] = '{1, 8'h22, 1};
    vecs[3] = '{3, 8'h40, -1};
    vecs[4] = '{3, 8'h41, -1};
    vecs[5] = '{3, 8'h42, -1};
    vecs[6] = '{3, 8'h43, -1};
    vecs[7] = '{3, 8'h44, -1};
    vecs[8] = '{2, 8'h5A, 2};
    vecs[9] = '{0, 8'hFF, 0};

    // reset
    areset = 1'b1;
    vif.response_in_valid   = 1'b0;
    vif.response_in_payload = '0;
    vif.rd_en               = '0;
    repeat (4) @(negedge ap_clk);
    check("rst out_valid", 32'(vif.response_out_valid), 0);
    check("rst empty", 32'(vif.fifo_empty), 32'h7);
    check("rst prog_full", 32'(vif.fifo_prog_full), 0);
    check("rst ready", 32'(vif.response_ready_out), 0);
    check("rst drop_count", 32'(vif.drop_count), 0);
    check("rst setup", 32'(vif.fifo_setup_signal), 1);
    areset = 1'b0;
    wait_ready("reset");

    // table: routing, drops, non-target ports stay silent
    for (int v = 0; v < 10; v++) begin
      clear_got();
      p = mk(vecs[v].dest, vecs[v].data);
      send(p);
      idle(4);
      pop('1, 3);
      idle(6);
      for (int q = 0; q < N; q++) begin
        check($sformatf("vec%0d port%0d count", v, q), 32'(got_q[q].size()),
              (vecs[v].exp_port == q) ? 1 : 0);
        if (vecs[v].exp_port == q && got_q[q].size() > 0)
          check($sformatf("vec%0d port%0d data", v, q), 32'(got_q[q][0]), 32'(p));
      end
      if (vecs[v].exp_port < 0) exp_drop++;
      check($sformatf("vec%0d drop_count", v), 32'(vif.drop_count), 32'(exp_drop));
    end
    check("drop_count after 5 misroutes", 32'(vif.drop_count), 5);

    // rd_en to response_out latency is three cycles, single pulse
    clear_got();
    p = mk(0, 8'h77);
    send(p);
    idle(5);
    @(negedge ap_clk); vif.rd_en = 3'b001;
    @(negedge ap_clk); vif.rd_en = '0;
    check("lat cyc1 valid", 32'(vif.response_out_valid), 0);
    @(negedge ap_clk);
    check("lat cyc2 valid", 32'(vif.response_out_valid), 0);
    @(negedge ap_clk);
    check("lat cyc3 valid", 32'(vif.response_out_valid), 32'h1);
    check("lat cyc3 data", 32'(vif.response_out_payload[0]), 32'(p));
    @(negedge ap_clk);
    check("lat cyc4 valid", 32'(vif.response_out_valid), 0);
    idle(4);
    clear_got();

    // prog_full boundary: 11 entries below threshold, 12 at threshold
    burst.delete();
    for (int k = 0; k < 12; k++) burst.push_back(mk(0, 8'(8'h60 + k)));
    for (int k = 0; k < 11; k++) send(burst[k]);
    idle(6);
    check("pf 11 prog_full", 32'(vif.fifo_prog_full), 0);
    check("pf 11 ready", 32'(vif.response_ready_out), 1);
    send(burst[11]);
    idle(6);
    check("pf 12 prog_full", 32'(vif.fifo_prog_full), 32'h1);
    check("pf 12 ready", 32'(vif.response_ready_out), 0);
    pop(3'b001, 12);
    idle(8);
    check("pf drain count", 32'(got_q[0].size()), 12);
    for (int k = 0; k < 12 && k < got_q[0].size(); k++)
      check($sformatf("pf drain order %0d", k), 32'(got_q[0][k]), 32'(burst[k]));
    check("pf drain ready", 32'(vif.response_ready_out), 1);
    check("pf drain empty", 32'(vif.fifo_empty), 32'h7);
    clear_got();

    // write into a full FIFO is discarded
    burst.delete();
    for (int k = 0; k < 17; k++) burst.push_back(mk(1, 8'(8'h80 + k)));
    for (int k = 0; k < 17; k++) send(burst[k]);
    idle(6);
    pop(3'b010, 20);
    idle(8);
    check("full drain count", 32'(got_q[1].size()), 16);
    for (int k = 0; k < 16 && k < got_q[1].size(); k++)
      check($sformatf("full order %0d", k), 32'(got_q[1][k]), 32'(burst[k]));
    check("full drain ready", 32'(vif.response_ready_out), 1);
    clear_got();

    // simultaneous pop of every port
    burst.delete();
    for (int k = 0; k < N; k++) begin
      burst.push_back(mk(k, 8'(8'hC0 + k)));
      send(burst[k]);
    end
    idle(5);
    @(negedge ap_clk); vif.rd_en = '1;
    @(negedge ap_clk); vif.rd_en = '0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    check("all-pop valid", 32'(vif.response_out_valid), 32'h7);
    for (int k = 0; k < N; k++)
      check($sformatf("all-pop data%0d", k), 32'(vif.response_out_payload[k]), 32'(burst[k]));
    idle(4);
    clear_got();

    // reset mid-operation with buffered and in-flight packets
    for (int k = 0; k < 6; k++) send(mk(k % N, 8'(8'hD0 + k)));
    send(mk(3, 8'hE0));
    send(mk(3, 8'hE1));
    idle(5);
    check("pre-reset drop_count", 32'(vif.drop_count), 32'(exp_drop + 2));
    check("pre-reset empty", 32'(vif.fifo_empty), 0);
    send(mk(0, 8'hEE));
    @(negedge ap_clk); vif.response_in_valid = 1'b0; areset = 1'b1;
    @(negedge ap_clk); areset = 1'b0;
    @(negedge ap_clk);
    check("mid-rst setup", 32'(vif.fifo_setup_signal), 1);
    check("mid-rst ready", 32'(vif.response_ready_out), 0);
    exp_drop = 0;
    wait_ready("mid-reset");
    check("mid-rst empty", 32'(vif.fifo_empty), 32'h7);
    check("mid-rst drop_count", 32'(vif.drop_count), 0);
    pop('1, 4);
    idle(6);
    for (int q = 0; q < N; q++)
      check($sformatf("mid-rst flushed port%0d", q), 32'(got_q[q].size()), 0);
    p = mk(1, 8'h99);
    send(p);
    idle(5);
    pop('1, 3);
    idle(6);
    check("post-rst port1 count", 32'(got_q[1].size()), 1);
    if (got_q[1].size() > 0) check("post-rst port1 data", 32'(got_q[1][0]), 32'(p));
    check("post-rst port0 count", 32'(got_q[0].size()), 0);
    check("post-rst port2 count", 32'(got_q[2].size()), 0);
    clear_got();

    // random traffic against per-destination queues
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge ap_clk);
      if (vif.response_ready_out === 1'b1 && vif.fifo_setup_signal === 1'b0 &&
          $urandom_range(0, 99) < 55) begin
        d = $urandom_range(0, 3);
        p = mk(d, 8'($urandom_range(0, 255)));
        vif.response_in_valid   = 1'b1;
        vif.response_in_payload = p;
        if (d < N) exp_q[d].push_back(p);
        else exp_drop++;
      end else begin
        vif.response_in_valid = 1'b0;
      end
      vif.rd_en = 3'($urandom_range(0, 7));
    end
    @(negedge ap_clk);
    vif.response_in_valid = 1'b0;
    vif.rd_en = '1;
    n = 0;
    while (n < 300 && (got_q[0].size() < exp_q[0].size() || got_q[1].size() < exp_q[1].size() ||
                       got_q[2].size() < exp_q[2].size())) begin
      @(negedge ap_clk);
      n++;
    end
    vif.rd_en = '0;
    idle(8);
    for (int q = 0; q < N; q++) begin
      check($sformatf("rand port%0d count", q), 32'(got_q[q].size()), 32'(exp_q[q].size()));
      for (int k = 0; k < exp_q[q].size() && k < got_q[q].size(); k++)
        check($sformatf("rand port%0d item%0d", q, k), 32'(got_q[q][k]), 32'(exp_q[q][k]));
    end
    check("rand drop_count", 32'(vif.drop_count), 32'(exp_drop));
    check("rand final empty", 32'(vif.fifo_empty), 32'h7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
